// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and constants for the two-requester BRAM port arbiter.
package bram_arb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } req_id_t;

  // One in-flight access: valid is set only for reads, id names the requester.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/bram_port_arbiter_rd_tag_pipe.sv
// Fixed-depth shift register of read tags; its output lines up with the
// cycle in which the BRAM presents the word for the tagged read.
module rd_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_stage [DEPTH];

  // Shift tags along every cycle; a reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two single-word clients.
// Grants are combinational, BRAM port signals are registered, and read data
// is routed back to its requester by a tag pipe matched to the read latency.
module bram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic [DATA_W/8-1:0]   m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic [DATA_W/8-1:0]   m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  bram_clk,
  output logic                  bram_rst,
  output logic                  bram_en,
  output logic [DATA_W/8-1:0]   bram_we,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic [DATA_W-1:0]     bram_din,
  input  logic [DATA_W-1:0]     bram_dout
);

  import bram_arb_pkg::*;

  req_id_t               r_last;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_xfer;
  logic [DATA_W/8-1:0]   w_we;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_wdata;
  rd_tag_t               w_tag_in;
  rd_tag_t               w_tag_out;

  // Round-robin pick: a lone requester always wins; on contention the one
  // that did not win last time goes. Nothing is granted while in reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset) begin
      w_gnt0 = m0_req && (!m1_req || (r_last == M1));
      w_gnt1 = m1_req && (!m0_req || (r_last == M0));
    end
  end

  assign w_xfer = w_gnt0 || w_gnt1;
  assign m0_gnt = w_gnt0;
  assign m1_gnt = w_gnt1;

  // Select the winning requester's fields for the issue registers.
  always_comb begin
    w_we    = m0_we;
    w_addr  = m0_addr;
    w_wdata = m0_wdata;
    if (w_gnt1) begin
      w_we    = m1_we;
      w_addr  = m1_addr;
      w_wdata = m1_wdata;
    end
  end

  // Remember the last winner; reset favours m0 for the first contended cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last <= M1;
    end else if (w_xfer) begin
      r_last <= w_gnt1 ? M1 : M0;
    end
  end

  // Registered BRAM port; address and data hold when idle, enables drop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bram_en   <= 1'b0;
      bram_we   <= '0;
      bram_addr <= '0;
      bram_din  <= '0;
    end else if (w_xfer) begin
      bram_en   <= 1'b1;
      bram_we   <= w_we;
      bram_addr <= w_addr;
      bram_din  <= w_wdata;
    end else begin
      bram_en   <= 1'b0;
      bram_we   <= '0;
    end
  end

  // Tag each transfer; only reads carry a valid tag back out.
  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_xfer && (w_we == '0);
    w_tag_in.id    = w_gnt1 ? M1 : M0;
  end

  // One stage for the issue register plus RD_LAT stages for the BRAM itself.
  rd_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign m0_rvalid = w_tag_out.valid && (w_tag_out.id == M0);
  assign m1_rvalid = w_tag_out.valid && (w_tag_out.id == M1);
  assign m0_rdata  = bram_dout;
  assign m1_rdata  = bram_dout;
  assign bram_clk  = clk;
  assign bram_rst  = 1'b0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: two instances (RD_LAT = 1 and 2) share the
// same request stimulus, each backed by its own BRAM model. A reference model
// predicts grants, port contents and read returns; read returns go into
// per-instance scoreboards that a separate monitor drains.
module tb_bram_port_arbiter;

  typedef struct {
    bit          idle;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [3:0]  m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;

  logic        m0_gnt_a, m1_gnt_a, m0_rvalid_a, m1_rvalid_a;
  logic [31:0] m0_rdata_a, m1_rdata_a;
  logic        bram_clk_a, bram_rst_a, bram_en_a;
  logic [3:0]  bram_we_a;
  logic [31:0] bram_addr_a, bram_din_a, dout_a;

  logic        m0_gnt_b, m1_gnt_b, m0_rvalid_b, m1_rvalid_b;
  logic [31:0] m0_rdata_b, m1_rdata_b;
  logic        bram_clk_b, bram_rst_b, bram_en_b;
  logic [3:0]  bram_we_b;
  logic [31:0] bram_addr_b, bram_din_b, dout_b;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [31:0] d1_a, d1_b, d2_b;

  req_t        rq0[$], rq1[$];
  exp_t        q_a[$], q_b[$];
  logic [31:0] ref_mem [64];
  bit          m_last;
  bit          x_en;
  logic [3:0]  x_we;
  logic [31:0] x_addr, x_din;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          dcnt0, dcnt1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt_a), .m0_rvalid(m0_rvalid_a), .m0_rdata(m0_rdata_a),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt_a), .m1_rvalid(m1_rvalid_a), .m1_rdata(m1_rdata_a),
    .bram_clk(bram_clk_a), .bram_rst(bram_rst_a), .bram_en(bram_en_a),
    .bram_we(bram_we_a), .bram_addr(bram_addr_a), .bram_din(bram_din_a),
    .bram_dout(dout_a)
  );

  bram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) u_dut_b (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt_b), .m0_rvalid(m0_rvalid_b), .m0_rdata(m0_rdata_b),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt_b), .m1_rvalid(m1_rvalid_b), .m1_rdata(m1_rdata_b),
    .bram_clk(bram_clk_b), .bram_rst(bram_rst_b), .bram_en(bram_en_b),
    .bram_we(bram_we_b), .bram_addr(bram_addr_b), .bram_din(bram_din_b),
    .bram_dout(dout_b)
  );

  // BRAM models: byte-lane writes, registered read (plus output reg for b).
  always @(posedge clk) begin
    if (bram_en_a) begin
      if (bram_we_a == 4'h0) d1_a <= mem_a[bram_addr_a[7:2]];
      for (int b = 0; b < 4; b++)
        if (bram_we_a[b]) mem_a[bram_addr_a[7:2]][8*b +: 8] <= bram_din_a[8*b +: 8];
    end
    if (bram_en_b) begin
      if (bram_we_b == 4'h0) d1_b <= mem_b[bram_addr_b[7:2]];
      for (int b = 0; b < 4; b++)
        if (bram_we_b[b]) mem_b[bram_addr_b[7:2]][8*b +: 8] <= bram_din_b[8*b +: 8];
    end
    d2_b <= d1_b;
  end
  assign dout_a = d1_a;
  assign dout_b = d2_b;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard drain for one instance at the current cycle.
  task automatic mon_lane(input bit lane, input logic v0, input logic v1,
                          input logic [31:0] d0, input logic [31:0] d1);
    exp_t  e;
    bit    have;
    string p;
    have = 1'b0;
    p = lane ? "lat2_" : "lat1_";
    if (!lane && q_a.size() > 0 && q_a[0].due == cyc) begin
      e = q_a.pop_front();
      have = 1'b1;
    end
    if (lane && q_b.size() > 0 && q_b[0].due == cyc) begin
      e = q_b.pop_front();
      have = 1'b1;
    end
    chk({p, "rvalid_exclusive"}, {63'b0, v0 && v1}, 64'd0);
    if (have) begin
      chk({p, "m0_rvalid"}, {63'b0, v0}, {63'b0, !e.id});
      chk({p, "m1_rvalid"}, {63'b0, v1}, {63'b0, e.id});
      chk({p, "rdata"}, {32'b0, e.id ? d1 : d0}, {32'b0, e.data});
    end else begin
      chk({p, "no_rvalid"}, {63'b0, v0 || v1}, 64'd0);
    end
  endtask

  always @(negedge clk) begin
    mon_lane(1'b0, m0_rvalid_a, m1_rvalid_a, m0_rdata_a, m1_rdata_a);
    mon_lane(1'b1, m0_rvalid_b, m1_rvalid_b, m0_rdata_b, m1_rdata_b);
  end

  // One clock of stimulus plus reference-model prediction and checks.
  task automatic step(input bit rst_n);
    req_t       c0, c1, w, dmy;
    exp_t       de;
    bit         had0, had1, r0, r1, g0, g1;
    logic [5:0] idx;
    c0 = '{idle: 1'b1, we: 4'h0, addr: 32'h0, wdata: 32'h0};
    c1 = c0;
    had0 = rq0.size() > 0;
    had1 = rq1.size() > 0;
    if (had0) c0 = rq0[0];
    if (had1) c1 = rq1[0];
    r0 = had0 && !c0.idle;
    r1 = had1 && !c1.idle;
    @(posedge clk);
    #1;
    reset    = rst_n;
    m0_req   = r0;
    m0_we    = r0 ? c0.we : 4'h0;
    m0_addr  = r0 ? c0.addr : 32'h0;
    m0_wdata = r0 ? c0.wdata : 32'h0;
    m1_req   = r1;
    m1_we    = r1 ? c1.we : 4'h0;
    m1_addr  = r1 ? c1.addr : 32'h0;
    m1_wdata = r1 ? c1.wdata : 32'h0;
    @(negedge clk);
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n) begin
      if (r0 && r1) begin
        if (m_last) g0 = 1'b1; else g1 = 1'b1;
      end else if (r0) begin
        g0 = 1'b1;
      end else if (r1) begin
        g1 = 1'b1;
      end
    end
    chk("lat1_gnt", {62'b0, m0_gnt_a, m1_gnt_a}, {62'b0, g0, g1});
    chk("lat2_gnt", {62'b0, m0_gnt_b, m1_gnt_b}, {62'b0, g0, g1});
    chk("lat1_port_ctl", {57'b0, bram_rst_a, bram_clk_a, bram_en_a, bram_we_a},
        {57'b0, 1'b0, 1'b0, x_en, x_we});
    chk("lat2_port_ctl", {57'b0, bram_rst_b, bram_clk_b, bram_en_b, bram_we_b},
        {57'b0, 1'b0, 1'b0, x_en, x_we});
    chk("lat1_port_addr", {32'b0, bram_addr_a}, {32'b0, x_addr});
    chk("lat2_port_addr", {32'b0, bram_addr_b}, {32'b0, x_addr});
    chk("lat1_port_din", {32'b0, bram_din_a}, {32'b0, x_din});
    chk("lat2_port_din", {32'b0, bram_din_b}, {32'b0, x_din});
    dcnt0 += int'(m0_gnt_a);
    dcnt1 += int'(m1_gnt_a);
    if (!rst_n) begin
      x_en = 1'b0; x_we = 4'h0; x_addr = 32'h0; x_din = 32'h0;
      m_last = 1'b1;
      while (q_a.size() > 0 && q_a[q_a.size()-1].due > cyc) de = q_a.pop_back();
      while (q_b.size() > 0 && q_b[q_b.size()-1].due > cyc) de = q_b.pop_back();
    end else if (g0 || g1) begin
      w = g1 ? c1 : c0;
      x_en = 1'b1; x_we = w.we; x_addr = w.addr; x_din = w.wdata;
      idx = w.addr[7:2];
      if (w.we == 4'h0) begin
        q_a.push_back('{id: g1, data: ref_mem[idx], due: cyc + 2});
        q_b.push_back('{id: g1, data: ref_mem[idx], due: cyc + 3});
      end else begin
        for (int b = 0; b < 4; b++)
          if (w.we[b]) ref_mem[idx][8*b +: 8] = w.wdata[8*b +: 8];
      end
      m_last = g1;
      if (g1) dmy = rq1.pop_front(); else dmy = rq0.pop_front();
    end else begin
      x_en = 1'b0; x_we = 4'h0;
    end
    if (had0 && c0.idle) dmy = rq0.pop_front();
    if (had1 && c1.idle) dmy = rq1.pop_front();
  endtask

  task automatic run(input int max);
    int n;
    n = 0;
    while ((rq0.size() > 0 || rq1.size() > 0) && n < max) begin
      step(1'b1);
      n++;
    end
    if (rq0.size() > 0 || rq1.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_timeout: got %0d pending expected 0", rq0.size() + rq1.size());
      rq0.delete();
      rq1.delete();
    end
  endtask

  function automatic req_t rnd_req();
    req_t r;
    int   k;
    r.idle  = ($urandom_range(0, 3) == 0);
    r.addr  = 32'($urandom_range(0, 63)) << 2;
    k       = $urandom_range(0, 3);
    r.we    = (k < 2) ? 4'h0 : (k == 2) ? 4'hF : 4'($urandom_range(1, 15));
    r.wdata = $urandom;
    return r;
  endfunction

  initial begin
    reset = 1'b0;
    m0_req = 1'b0; m0_we = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
    m_last = 1'b1;
    x_en = 1'b0; x_we = 4'h0; x_addr = 32'h0; x_din = 32'h0;
    dcnt0 = 0; dcnt1 = 0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 32'h0;
      mem_a[i]   = 32'h0;
      mem_b[i]   = 32'h0;
    end

    // Reset with both requesting, then continuous contention.
    for (int i = 0; i < 5; i++) begin
      rq0.push_back('{idle: 1'b0, we: 4'hF, addr: 32'(64 + 4*i), wdata: $urandom});
      rq1.push_back('{idle: 1'b0, we: 4'h0, addr: 32'(64 + 4*i), wdata: 32'h0});
    end
    repeat (3) step(1'b0);
    dcnt0 = 0; dcnt1 = 0;
    repeat (10) step(1'b1);
    chk("contend_m0_share", 64'(dcnt0), 64'd5);
    chk("contend_m1_share", 64'(dcnt1), 64'd5);
    run(4);
    repeat (4) step(1'b1);

    // Single writer, then read-back from the other requester.
    for (int i = 1; i <= 10; i++)
      rq0.push_back('{idle: 1'b0, we: 4'hF, addr: 32'(4*(i-1)), wdata: 32'(10*i)});
    run(20);
    for (int i = 1; i <= 10; i++)
      rq1.push_back('{idle: 1'b0, we: 4'h0, addr: 32'(4*(i-1)), wdata: 32'h0});
    run(20);
    repeat (4) step(1'b1);

    // Write and read of the same word in the same cycle.
    rq0.push_back('{idle: 1'b0, we: 4'hF, addr: 32'd8, wdata: 32'h55});
    rq1.push_back('{idle: 1'b0, we: 4'h0, addr: 32'd8, wdata: 32'h0});
    run(5);
    repeat (4) step(1'b1);

    // Reset the cycle after a read; the read must never return.
    rq0.push_back('{idle: 1'b0, we: 4'h0, addr: 32'd4, wdata: 32'h0});
    step(1'b1);
    rq0.push_back('{idle: 1'b0, we: 4'hF, addr: 32'd12, wdata: 32'hA5A5_0F0F});
    rq1.push_back('{idle: 1'b0, we: 4'h0, addr: 32'd12, wdata: 32'h0});
    step(1'b0);
    step(1'b0);
    run(5);
    repeat (4) step(1'b1);

    // Random mixed traffic.
    repeat (150) begin
      rq0.push_back(rnd_req());
      rq1.push_back(rnd_req());
    end
    run(1000);
    repeat (6) step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
